// File: rtl/mem_port_arbiter.sv
// Shared single-port memory arbiter between instruction fetch and data access.
// Data wins ties; a streak counter forces a fetch grant. Optional macro: ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [3:0]        dm_size,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_size,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;   // 1 = data requester owns the port
    logic [3:0]        streak_q, streak_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_size_q, mem_size_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic              grant_dm, grant_if;
    logic              timeout_hit;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
    logic [7:0] wait_q, wait_d;
    logic       err_q, err_d;
    // ack in the final wait cycle takes precedence over the abort
    assign timeout_hit = (state_q == BUSY) && !mem_ack && (wait_q + 8'd1 == TO_LIM);
    assign err         = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    assign grant_dm = dm_req && (!if_req || streak_q != STARVE_LIM);
    assign grant_if = if_req && !grant_dm;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_size_d  = mem_size_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_done_d   = if_done_q;
        dm_done_d   = dm_done_q;
`ifdef ARB_TIMEOUT_EN
        wait_d      = wait_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_dm || grant_if) begin
                    state_d   = BUSY;
                    owner_d   = grant_dm;
                    mem_req_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    wait_d    = 8'd0;
`endif
                    if (grant_dm) begin
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        mem_size_d  = dm_size;
                        if (if_req && streak_q != STARVE_LIM)
                            streak_d = streak_q + 4'd1;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_size_d  = 4'd8;
                        streak_d    = 4'd0;
                    end
                end
            end
            BUSY: begin
                if (mem_ack || timeout_hit) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    if (owner_q) begin
                        dm_done_d  = 1'b1;
                        dm_rdata_d = (mem_ack && !mem_we_q) ? mem_rdata : '0;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = !mem_ack ? 32'd0 :
                                     (if_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0]);
                    end
`ifdef ARB_TIMEOUT_EN
                    err_d = !mem_ack;
                end else begin
                    wait_d = wait_q + 8'd1;
`endif
                end
            end
            DONE: begin
                state_d   = IDLE;
                if_done_d = 1'b0;
                dm_done_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
                err_d     = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            streak_q    <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= 4'd0;
            if_rdata_q  <= 32'd0;
            dm_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wait_q      <= 8'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_size_q  <= mem_size_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
`ifdef ARB_TIMEOUT_EN
            wait_q      <= wait_d;
            err_q       <= err_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_size  = mem_size_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_stall  = if_req & ~if_done_q;
    assign dm_stall  = dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected completions,
// a negedge monitor pops and compares on every done pulse.
module tb_mem_port_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [AW-1:0] if_addr = '0, dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [3:0]    dm_size = 4'd0;
    logic [31:0]   if_rdata;
    logic [DW-1:0] dm_rdata, mem_wdata, mem_rdata = '0;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_size;
    logic          if_done, if_stall, dm_done, dm_stall;
    logic          mem_req, mem_we, mem_ack = 1'b0, err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4), .TIMEOUT(5)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_size(dm_size),
        .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
    );

    typedef struct packed {
        logic        dm;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int checks = 0, errors = 0, ndone = 0;

    // memory responder knobs
    bit          ack_en = 1'b1;
    int          ack_delay = 0;
    logic [63:0] rd_cfg = '0;
    int          rcnt = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_req && reset) begin
            if (ack_en && rcnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = rd_cfg;
                rcnt      = 0;
            end else begin
                mem_ack = 1'b0;
                rcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            rcnt    = 0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset && (if_done || dm_done)) begin
            ndone++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: if_done=%0b dm_done=%0b with empty queue", if_done, dm_done);
            end else begin
                e = sb.pop_front();
                chk("done_owner", {62'd0, if_done, dm_done}, {62'd0, !e.dm, e.dm});
                chk("done_rdata", e.dm ? dm_rdata : {32'd0, if_rdata}, e.rdata);
                chk("done_err", {63'd0, err}, {63'd0, e.err});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done_neg(string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (if_done || dm_done) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: no done within 60 cycles", name);
    endtask

    function automatic exp_t mk(logic dm, logic [63:0] rd, logic e);
        exp_t x;
        x.dm = dm; x.rdata = rd; x.err = e;
        return x;
    endfunction

    initial begin
        int n;
        #12;
        // reset state
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_dones", {62'd0, if_done, dm_done}, 64'd0);
        chk("rst_mem_size", {60'd0, mem_size}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // single fetch, upper word selected by addr bit 2
        tick();
        rd_cfg = 64'hAAAA_BBBB_CCCC_DDDD;
        if_addr = 64'h104; if_req = 1'b1;
        sb.push_back(mk(1'b0, 64'hAAAABBBB, 1'b0));
        #1 chk("f_stall_c0", {63'd0, if_stall}, 64'd1);
        tick();
        chk("f_mem_req_c1", {63'd0, mem_req}, 64'd1);
        chk("f_mem_addr", mem_addr, 64'h104);
        chk("f_mem_size", {60'd0, mem_size}, 64'd8);
        chk("f_mem_we", {63'd0, mem_we}, 64'd0);
        chk("f_stall_c1", {63'd0, if_stall}, 64'd1);
        tick();
        chk("f_done_c2", {63'd0, if_done}, 64'd1);
        chk("f_stall_c2", {63'd0, if_stall}, 64'd0);
        if_req = 1'b0;
        tick();
        chk("f_done_c3", {63'd0, if_done}, 64'd0);

        // data write, ack after 3 wait cycles
        ack_delay = 3;
        rd_cfg = 64'hDEAD_BEEF_0000_FFFF;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h40; dm_wdata = 64'h1234; dm_size = 4'd8;
        sb.push_back(mk(1'b1, 64'd0, 1'b0));
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_req) begin
                n++;
                chk("w_mem_bus", {mem_we, mem_addr[14:0], mem_wdata[47:0]}, {1'b1, 15'h40, 48'h1234});
            end
            if (dm_done) break;
        end
        chk("w_busy_cycles", 64'(n), 64'd4);
        dm_req = 1'b0; dm_we = 1'b0;
        tick();

        // contention: data x4, fetch, data x4, fetch
        ack_delay = 0;
        rd_cfg = 64'h1111_2222_3333_4444;
        if_addr = 64'h100; dm_addr = 64'h80; dm_we = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) sb.push_back(mk(1'b1, 64'h1111_2222_3333_4444, 1'b0));
            sb.push_back(mk(1'b0, 64'h33334444, 1'b0));
        end
        n = ndone;
        if_req = 1'b1; dm_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (ndone >= n + 10) break;
        end
        if_req = 1'b0; dm_req = 1'b0;
        chk("c_completions", 64'(ndone - n), 64'd10);
        tick(); tick();
        chk("c_idle_after", {63'd0, mem_req}, 64'd0);

        // request held through DONE is ignored there, regranted from IDLE
        rd_cfg = 64'h0102_0304_0506_0708;
        dm_addr = 64'h88; dm_req = 1'b1;
        sb.push_back(mk(1'b1, 64'h0102_0304_0506_0708, 1'b0));
        sb.push_back(mk(1'b1, 64'h0102_0304_0506_0708, 1'b0));
        wait_done_neg("di_first");
        tick();
        chk("di_idle_mem_req", {63'd0, mem_req}, 64'd0);
        chk("di_idle_done", {63'd0, dm_done}, 64'd0);
        tick();
        chk("di_regrant", {63'd0, mem_req}, 64'd1);
        wait_done_neg("di_second");
        dm_req = 1'b0;
        tick(); tick();

        // async reset mid-BUSY with fetch owner
        ack_en = 1'b0;
        rd_cfg = 64'h5555_6666_7777_8888;
        if_addr = 64'h200; if_req = 1'b1;
        tick(); tick();
        chk("r_pre_mem_req", {63'd0, mem_req}, 64'd1);
        chk("r_pre_mem_addr", mem_addr, 64'h200);
        #2 reset = 1'b0;
        #1;
        chk("r_mem_bus", {mem_req, mem_we, mem_addr[30:0], mem_size, mem_wdata[27:0]}, 64'd0);
        chk("r_outs", {if_done, dm_done, err, if_rdata, dm_rdata[28:0]}, 64'd0);
        ack_en = 1'b1;
        sb.push_back(mk(1'b0, 64'h77778888, 1'b0));
        @(negedge clk);
        reset = 1'b1;
        wait_done_neg("r_resume");
        if_req = 1'b0;
        tick(); tick();

`ifdef ARB_TIMEOUT_EN
        // timeout with no ack, then ack in the last allowed cycle
        for (int pass = 0; pass < 2; pass++) begin
            ack_en = (pass == 1);
            ack_delay = 4;
            rd_cfg = 64'h9999_AAAA_BBBB_CCCC;
            if_addr = 64'h0; if_req = 1'b1;
            sb.push_back(pass == 0 ? mk(1'b0, 64'd0, 1'b1) : mk(1'b0, 64'hBBBBCCCC, 1'b0));
            n = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (mem_req) n++;
                if (if_done) break;
            end
            chk("t_busy_cycles", 64'(n), 64'd5);
            chk("t_mem_req_at_done", {63'd0, mem_req}, 64'd0);
            if_req = 1'b0;
            tick(); tick();
        end
        ack_en = 1'b1;
`endif

        tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
